// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, CP0 register numbers, SR field
// layout and the exception-sequencer state encoding.
package cpu_pkg;

  // Fetch redirect target loaded into every stage register on Req.
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  // Processor ID returned by reads of CP0 register 15.
  localparam logic [31:0] PRID       = 32'h2022_0707;

  // Exception codes carried down the pipeline into M.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register numbers.
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR: IM[15:10], EXL[1], IE[0] are the only implemented bits.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;
  localparam int SR_IE_BIT   = 0;
  localparam int SR_EXL_BIT  = 1;
  localparam int SR_IM_LSB   = 10;

  // Cause: BD[31], IP[15:10], ExcCode[6:2].
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  // Exception sequencer states.
  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    IN_HANDLER = 2'd1,
    ERET_DRAIN = 2'd2
  } exc_state_e;

endpackage

// File: rtl/cp0_regs.sv
// CP0 storage (SR, Cause, EPC): exception capture, mtc0 write masking and
// the combinational read mux.
module cp0_regs
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_int,
  input  logic [4:0]  req_code,
  input  logic        req_bd,
  input  logic [31:0] req_pc,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  sr_im,
  output logic        sr_exl,
  output logic        sr_ie,
  output logic [31:0] epc
);

  logic [31:0] sr_reg, sr_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] sr_wdata;

  // Unimplemented SR bits are forced to zero on write so they always read 0.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sr_wmask
    assign sr_wdata[gi] = SR_WMASK[gi] & wdata[gi];
  end

  // SR update: exception entry sets EXL and overrides any mtc0; eret clears EXL.
  always_comb begin
    sr_next = sr_reg;
    if (req) begin
      sr_next[SR_EXL_BIT] = 1'b1;
    end else begin
      if (we && addr == CP0_SR) begin
        sr_next = sr_wdata;
      end
      if (eret) begin
        sr_next[SR_EXL_BIT] = 1'b0;
      end
    end
  end

  // Cause update: IP tracks the interrupt lines every cycle; BD/ExcCode on entry.
  always_comb begin
    cause_next = cause_reg;
    cause_next[CAUSE_IP_LSB +: 6] = hw_int;
    if (req) begin
      cause_next[CAUSE_BD_BIT] = req_bd;
      cause_next[CAUSE_EXC_LSB +: 5] = req_int ? EXC_INT : req_code;
    end
  end

  // EPC update: a delay-slot fault restarts at the branch (PC-4, mod 2^32).
  always_comb begin
    epc_next = epc_reg;
    if (req) begin
      epc_next = req_bd ? (req_pc - 32'd4) : req_pc;
    end else if (we && addr == CP0_EPC) begin
      epc_next = wdata;
    end
  end

  // CP0 state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_reg    <= '0;
      cause_reg <= '0;
      epc_reg   <= '0;
    end else begin
      sr_reg    <= sr_next;
      cause_reg <= cause_next;
      epc_reg   <= epc_next;
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR:    rdata = sr_reg;
      CP0_CAUSE: rdata = cause_reg;
      CP0_EPC:   rdata = epc_reg;
      CP0_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

  assign sr_im  = sr_reg[SR_IM_LSB +: 6];
  assign sr_exl = sr_reg[SR_EXL_BIT];
  assign sr_ie  = sr_reg[SR_IE_BIT];
  assign epc    = epc_reg;

endmodule

// File: rtl/pipe_exc_ctrl.sv
// Pipeline controller: hazard/MDU stall generation, M-stage exception and
// interrupt detection, the global Req flush and the exception state machine.
module pipe_exc_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        D_is_mdu,
  input  logic        E_mdu_start,
  input  logic        mdu_busy,
  input  logic [4:0]  M_EXCcode,
  input  logic        M_BD,
  input  logic [31:0] M_PC,
  input  logic        M_eret,
  input  logic [5:0]  HWInt,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        Req,
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic [31:0] EPC_out
);

  exc_state_e state_reg, state_next;

  logic [5:0] sr_im;
  logic       sr_exl;
  logic       sr_ie;
  logic       int_req;
  logic       exc_req;
  logic       req;
  logic       stall;
  logic       sr_write;

  // Pending interrupt/exception; the one-cycle ERET_DRAIN window lets the
  // instruction at EPC enter before another interrupt is taken.
  always_comb begin
    int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl & (state_reg != ERET_DRAIN);
    exc_req = (M_EXCcode != EXC_INT) & ~sr_exl;
    req     = (int_req | exc_req) & reset;
  end

  // Stage controls: a flush overrides any stall so the handler PC loads.
  always_comb begin
    stall   = hazard_stall | (D_is_mdu & (E_mdu_start | mdu_busy));
    F_en    = ~stall;
    D_en    = ~stall;
    E_flush = stall;
    if (req) begin
      F_en    = 1'b1;
      D_en    = 1'b1;
      E_flush = 1'b0;
    end
  end

  assign sr_write = cp0_we & (cp0_addr == CP0_SR) & ~req;

  // Next state: entry, eret drain, and software moves via mtc0 to SR.EXL.
  always_comb begin
    state_next = state_reg;
    if (req) begin
      state_next = IN_HANDLER;
    end else if (M_eret) begin
      state_next = ERET_DRAIN;
    end else if (sr_write) begin
      if (!cp0_wdata[SR_EXL_BIT]) begin
        state_next = NORMAL;
      end else begin
        case (state_reg)
          NORMAL:     state_next = IN_HANDLER;
          ERET_DRAIN: state_next = NORMAL;
          default:    state_next = state_reg;
        endcase
      end
    end else if (state_reg == ERET_DRAIN) begin
      state_next = NORMAL;
    end
  end

  // Exception state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  cp0_regs u_cp0 (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_int  (int_req),
    .req_code (M_EXCcode),
    .req_bd   (M_BD),
    .req_pc   (M_PC),
    .eret     (M_eret),
    .hw_int   (HWInt),
    .we       (cp0_we),
    .addr     (cp0_addr),
    .wdata    (cp0_wdata),
    .rdata    (cp0_rdata),
    .sr_im    (sr_im),
    .sr_exl   (sr_exl),
    .sr_ie    (sr_ie),
    .epc      (EPC_out)
  );

  assign Req = req;

endmodule

// File: tb/tb_pipe_exc_ctrl.sv
// Self-checking bench for pipe_exc_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural CP0/flush model.
module tb_pipe_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        D_is_mdu = 1'b0;
  logic        E_mdu_start = 1'b0;
  logic        mdu_busy = 1'b0;
  logic [4:0]  M_EXCcode = '0;
  logic        M_BD = 1'b0;
  logic [31:0] M_PC = '0;
  logic        M_eret = 1'b0;
  logic [5:0]  HWInt = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata;
  logic        Req;
  logic        F_en;
  logic        D_en;
  logic        E_flush;
  logic [31:0] EPC_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (architectural view only).
  bit        m_exl, m_ie, m_bd, m_drain;
  bit [5:0]  m_im, m_ip;
  bit [4:0]  m_code;
  bit [31:0] m_epc;

  pipe_exc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .D_is_mdu     (D_is_mdu),
    .E_mdu_start  (E_mdu_start),
    .mdu_busy     (mdu_busy),
    .M_EXCcode    (M_EXCcode),
    .M_BD         (M_BD),
    .M_PC         (M_PC),
    .M_eret       (M_eret),
    .HWInt        (HWInt),
    .cp0_we       (cp0_we),
    .cp0_addr     (cp0_addr),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .Req          (Req),
    .F_en         (F_en),
    .D_en         (D_en),
    .E_flush      (E_flush),
    .EPC_out      (EPC_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exl = 0; m_ie = 0; m_bd = 0; m_drain = 0;
    m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'h0, m_ip, 3'b0, m_code, 2'b0};
      5'd14:   return m_epc;
      5'd15:   return 32'h2022_0707;
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle: check combinational outputs at the falling edge against
  // the model, then advance the model on the rising edge.
  task automatic cycle(input string tag);
    bit ir, er, rq, st;
    @(negedge clk);
    ir = (|(HWInt & m_im)) && m_ie && !m_exl && !m_drain;
    er = (M_EXCcode != 5'd0) && !m_exl;
    rq = ir || er;
    st = hazard_stall || (D_is_mdu && (E_mdu_start || mdu_busy));
    check({tag, ".req"},    {31'b0, Req},     {31'b0, rq});
    check({tag, ".f_en"},   {31'b0, F_en},    {31'b0, rq || !st});
    check({tag, ".d_en"},   {31'b0, D_en},    {31'b0, rq || !st});
    check({tag, ".e_flush"},{31'b0, E_flush}, {31'b0, !rq && st});
    check({tag, ".rdata"},  cp0_rdata,        model_read(cp0_addr));
    check({tag, ".epc"},    EPC_out,          m_epc);
    $display("%s: req=%0b f_en=%0b d_en=%0b e_flush=%0b addr=%0d rdata=%08h epc=%08h",
             tag, Req, F_en, D_en, E_flush, cp0_addr, cp0_rdata, EPC_out);
    @(posedge clk);
    if (rq) begin
      m_epc   = M_BD ? (M_PC - 32'd4) : M_PC;
      m_bd    = M_BD;
      m_code  = ir ? 5'd0 : M_EXCcode;
      m_exl   = 1;
      m_drain = 0;
    end else if (M_eret) begin
      m_exl   = 0;
      m_drain = 1;
    end else begin
      m_drain = 0;
      if (cp0_we && cp0_addr == 5'd12) begin
        m_im  = cp0_wdata[15:10];
        m_exl = cp0_wdata[1];
        m_ie  = cp0_wdata[0];
      end
      if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
    end
    m_ip = HWInt;
    #1;
  endtask

  task automatic idle_inputs();
    hazard_stall = 0; D_is_mdu = 0; E_mdu_start = 0; mdu_busy = 0;
    M_EXCcode = '0; M_BD = 0; M_eret = 0; cp0_we = 0;
  endtask

  initial begin
    model_reset();
    // Reset values, observed while reset is held low.
    #2;
    check("rst.req", {31'b0, Req}, 32'd0);
    check("rst.f_en", {31'b0, F_en}, 32'd1);
    check("rst.d_en", {31'b0, D_en}, 32'd1);
    check("rst.e_flush", {31'b0, E_flush}, 32'd0);
    for (int a = 12; a <= 14; a++) begin
      cp0_addr = 5'(a);
      #1;
      check("rst.rdata", cp0_rdata, 32'd0);
    end
    #7 reset = 1'b1;

    // Load-use stall for two cycles, then normal flow.
    hazard_stall = 1;
    cycle("stall1");
    cycle("stall2");
    hazard_stall = 0;
    cycle("stall_end");

    // Overflow exception.
    M_EXCcode = 5'd12; M_PC = 32'h3010; M_BD = 0;
    cycle("ov");
    M_EXCcode = 0; cp0_addr = 5'd13;
    check("ov.epc_const", EPC_out, 32'h3010);
    cycle("ov.cause");
    cp0_addr = 5'd12;
    cycle("ov.sr");
    M_EXCcode = 5'd4; M_PC = 32'h3100;
    cycle("ov.masked");

    // Leave handler by software, then a delay-slot exception.
    M_EXCcode = 0; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
    cycle("sr_clr");
    cp0_we = 0; M_EXCcode = 5'd10; M_BD = 1; M_PC = 32'h3024;
    cycle("bd");
    M_EXCcode = 0; M_BD = 0; cp0_addr = 5'd13;
    check("bd.epc_const", EPC_out, 32'h3020);
    cycle("bd.cause");

    // Interrupt enable, then interrupt taken over a simultaneous stall.
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    cycle("sr_int");
    cp0_we = 0; HWInt = 6'b000001; hazard_stall = 1; M_PC = 32'h3040;
    cycle("int");
    hazard_stall = 0; cp0_addr = 5'd13;
    cycle("int.cause");

    // eret with the interrupt line still high.
    M_eret = 1; M_PC = 32'h3050; cp0_addr = 5'd12;
    cycle("eret");
    M_eret = 0; M_PC = 32'h3040;
    cycle("drain");
    cycle("int2");
    check("int2.epc_const", EPC_out, 32'h3040);

    // Asynchronous reset between edges while in the handler with a fault pending.
    M_EXCcode = 5'd12;
    #2 reset = 1'b0;
    #1;
    check("arst.req", {31'b0, Req}, 32'd0);
    check("arst.sr", cp0_rdata, 32'd0);
    cp0_addr = 5'd14;
    #1;
    check("arst.epc", cp0_rdata, 32'd0);
    model_reset();
    idle_inputs();
    HWInt = 0;
    @(posedge clk);
    #2 reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      hazard_stall = 1'($urandom_range(0, 3) == 0);
      D_is_mdu     = 1'($urandom_range(0, 1));
      E_mdu_start  = 1'($urandom_range(0, 3) == 0);
      mdu_busy     = 1'($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0: M_EXCcode = 5'd4;
        1: M_EXCcode = 5'd5;
        2: M_EXCcode = 5'd10;
        3: M_EXCcode = 5'd12;
        default: M_EXCcode = 5'd0;
      endcase
      M_BD    = 1'($urandom_range(0, 1));
      M_PC    = $urandom;
      HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      M_eret  = 1'($urandom_range(0, 5) == 0);
      cp0_we  = M_eret ? 1'b0 : 1'($urandom_range(0, 5) == 0);
      cp0_addr = 5'($urandom_range(10, 17));
      cp0_wdata = $urandom;
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_exc_ctrl.md
# pipe_exc_ctrl

Central pipeline controller and exception sequencer for the five-stage CPU. Combines load-use/MDU hazard stalls with M-stage exception and interrupt detection. Drives per-stage enable/bubble controls and the global `Req` flush consumed by every stage register, which loads the handler PC on `Req`. Holds the CP0 state (SR, Cause, EPC) that the handler and `eret` depend on.

## Interface
- `HANDLER_PC`, 32'h0000_4180, PC loaded into stage registers on `Req`; exported for the fetch redirect.
- `PRID`, 32'h2022_0707, constant value read at CP0 register 15.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `hazard_stall` in 1: D-stage load-use or forwarding stall request from the hazard detector.
- `D_is_mdu` in 1: the D-stage instruction uses the MDU.
- `E_mdu_start` in 1: the E-stage instruction starts a multiply/divide this cycle.
- `mdu_busy` in 1: MDU operation in progress.
- `M_EXCcode` in 5: M-stage exception code; 0 means no exception.
- `M_BD` in 1: the M-stage instruction sits in a delay slot.
- `M_PC` in 32: M-stage PC.
- `M_eret` in 1: `eret` in M.
- `HWInt` in 6: external interrupt lines, level-sensitive.
- `cp0_we` in 1: `mtc0` commit in M.
- `cp0_addr` in 5: CP0 register number.
- `cp0_wdata` in 32: write data.
- `cp0_rdata` out 32: combinational read data.
- `Req` out 1: flush all stage registers and redirect to `HANDLER_PC`.
- `F_en` out 1: PC/F-register enable.
- `D_en` out 1: D-register enable.
- `E_flush` out 1: insert a bubble into the E register.
- `EPC_out` out 32: current EPC, used as the `eret` target.

## Operation
- Interrupt pending: `int_req = |(HWInt & SR.IM[15:10]) & SR.IE[0] & ~SR.EXL[1] & (state != ERET_DRAIN)`.
- Exception pending: `exc_req = (M_EXCcode != 0) & ~SR.EXL`.
- `Req = int_req | exc_req`. Forced to 0 while `reset` is low.
- Stall: `stall = hazard_stall | (D_is_mdu & (E_mdu_start | mdu_busy))`.
- Normal outputs: `F_en = D_en = ~stall`, `E_flush = stall`.
- If `Req`, force `F_en = D_en = 1` and `E_flush = 0`; `Req` wins over any stall.
- On the clock edge with `Req`:
  - EPC ← `M_BD ? M_PC-4 : M_PC`.
  - Cause.BD[31] ← `M_BD`.
  - Cause.ExcCode[6:2] ← `int_req ? 0 : M_EXCcode`; interrupt has priority over exception.
  - SR.EXL ← 1.
  - state → IN_HANDLER.
- `M_eret` with no `Req`: SR.EXL ← 0, state → ERET_DRAIN.
- `cp0_we` is ignored in any cycle with `Req`. Otherwise it writes:
  - addr 12: SR, writable bits IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - addr 14: EPC, full 32 bits.
  - addr 13 and 15: read-only, writes dropped.
- Cause.IP[15:10] ← `HWInt` every cycle, unconditionally.
- Reads: 12 SR, 13 Cause, 14 EPC, 15 `PRID`, any other address 0. Reads are combinational and reflect pre-edge values.
- FSM states:
  - NORMAL: exceptions and interrupts accepted.
  - IN_HANDLER: EXL=1; everything is masked by EXL.
  - ERET_DRAIN: lasts exactly one cycle and blocks `int_req`, so the instruction at EPC enters the pipeline. Then → NORMAL. Exceptions are still accepted here.
- An `mtc0` that sets EXL while in NORMAL moves state → IN_HANDLER. An `mtc0` that clears EXL moves state → NORMAL.

## Timing
- Reset values:
  - SR, Cause and EPC are 0; state is NORMAL.
  - `Req`=0, `F_en`=`D_en`=1, `E_flush`=0.
  - `cp0_rdata` is 0 for addr 12/13/14.
- `Req`, the stall outputs and `cp0_rdata` are combinational, with zero-cycle latency. Registered CP0 state is visible the cycle after the edge.
- Simultaneous `Req` and `M_eret` (interrupt on `eret`): `Req` wins; EPC ← `eret` PC and EXL stays 1.
- Simultaneous `Req` and `cp0_we`: the write is dropped and exception state is written.
- Reset asserted mid-stall or mid-handler: immediate return to reset values without waiting for the clock.
- `M_PC - 4` wraps modulo 2^32.

## Structure
- Shared package `cpu_pkg` holds:
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
  - CP0 register numbers 12–15.
  - Writable-bit masks for SR.
  - The FSM state enum {NORMAL, IN_HANDLER, ERET_DRAIN}.
- One sub-module, `cp0_regs`: holds the SR/Cause/EPC storage, write masking and read mux. The top level keeps the FSM, `Req` and the stall logic.

## Test plan
- Load-use stall: `hazard_stall`=1 for 2 cycles → `F_en`=`D_en`=0 and `E_flush`=1 in both cycles; normal outputs resume on cycle 3.
- Overflow exception: `M_EXCcode`=12, `M_PC`=0x3010, `M_BD`=0 → `Req`=1 for one cycle; next cycle EPC=0x3010, Cause[6:2]=12, SR.EXL=1. A second exception while EXL=1 → `Req`=0.
- Delay-slot exception: `M_BD`=1, `M_PC`=0x3024 → EPC=0x3020 and Cause[31]=1.
- Interrupt: `mtc0` SR=0x0000_0401, then `HWInt`=6'b000001 → `Req`=1 and Cause.ExcCode=0. With `hazard_stall`=1 in the same cycle, `F_en`=1 and `E_flush`=0.
- `eret` with `HWInt` held high: EXL clears and `Req`=0 during the ERET_DRAIN cycle; `Req`=1 in the following cycle.
- Async reset: drop `reset` between edges while in IN_HANDLER → SR/EPC read 0 immediately and `Req`=0.
